spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
- Frame-level controller between the SPI byte shifter and the PWM register bank in sbasu3_top.
- Decodes each SPI frame (header byte, then DATA_W/8 data bytes), issues register write/read strobes, and feeds read data back to the shifter byte by byte.
- Runs entirely in the sys_clk domain; ss/rx strobes arrive already synchronised from the shifter.

Parameters:
- ADDR_W, 3, register address width (header bits [ADDR_W-1:0]; header bits [6:ADDR_W] must be 0).
- NUM_REGS, 4, number of implemented registers; addresses >= NUM_REGS are invalid.
- DATA_W, 16, register width; multiple of 8, MSB byte first on the wire.

Ports:
- sys_clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- ss_act, in, 1, frame active (ss high), synchronised.
- rx_valid, in, 1, one-cycle strobe: rx_byte holds a complete received byte.
- rx_byte, in, 8, received byte.
- tx_load, out, 1, one-cycle strobe: shifter loads tx_byte for the next byte slot.
- tx_byte, out, 8, byte to shift out on miso.
- reg_addr, out, ADDR_W, register address.
- reg_wdata, out, DATA_W, write data.
- reg_we, out, 1, one-cycle write strobe.
- reg_re, out, 1, one-cycle read strobe; reg_rdata is combinational and sampled in the same cycle.
- reg_rdata, in, DATA_W, read data.
- frame_err, out, 1, one-cycle pulse on aborted frame or invalid address.
- busy, out, 1, high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE.
  - tx_byte=0x00, reg_addr=0, reg_wdata=0.
  - tx_load, reg_we, reg_re, frame_err, busy all 0.
  - Word buffer and byte counter cleared.
- Header format: bit7 rw (1=read), bits[6:0] address.
- FSM states: IDLE, HDR, WDATA, RREQ, RDATA, DRAIN.
- IDLE -> HDR when ss_act rises.
- HDR, on rx_valid:
  - Invalid address: frame_err pulse next cycle, -> DRAIN.
  - Valid write (rw=0): latch addr, -> WDATA.
  - Valid read (rw=1): latch addr, -> RREQ.
- WDATA:
  - Each rx_valid shifts rx_byte into the word buffer (MSB first).
  - On byte DATA_W/8: reg_we=1 with reg_addr/reg_wdata one cycle after that rx_valid, then -> DRAIN.
- RREQ:
  - reg_re=1 for exactly one cycle (cycle after the header rx_valid); reg_rdata captured in that cycle.
  - Next cycle: tx_byte=MSB byte, tx_load=1, -> RDATA.
- RDATA:
  - Each rx_valid (dummy byte) -> next cycle tx_load=1 with the next lower byte.
  - After the last byte is sent: -> DRAIN, tx_byte=0x00.
- DRAIN: rx_valid is ignored; tx_byte stays 0x00.
- Any state except IDLE: ss_act=0 -> IDLE next cycle.
  - Incomplete frame (HDR with no bytes is not an error; WDATA/RDATA partial is) -> frame_err pulse.
  - Partial write discarded; no reg_we.
- rx_valid together with an ss_act fall in the same cycle: the abort wins and the byte is discarded.
- rx_valid in IDLE is ignored.
- Strobes are never asserted in consecutive cycles except tx_load under back-to-back rx_valid.

Optional Feature:
- SPI_CMD_AUTOINC_EN defined:
  - After a completed write or read word, state returns to WDATA/RDATA with reg_addr+1 (burst).
  - reg_addr wraps at NUM_REGS-1 -> 0.
  - Read burst issues RREQ again.
- Undefined: the post-word state is always DRAIN.

Decomposition:
- Package/include spi_cmd_pkg:
  - State encodings.
  - RW_BIT=7.
  - BYTES_PER_WORD=DATA_W/8.
  - TX_IDLE_BYTE=8'h00.
- Sub-module spi_word_buf: the byte<->word shift buffer with byte counter (load parallel, shift byte in/out, count==last flag).

Test Plan:
- ss up; bytes 0x00, 0x08, 0x08 -> single reg_we, reg_addr=0, reg_wdata=0x0808, one cycle after the third rx_valid; no frame_err.
- Header 0x80 with reg_rdata=0x0808 -> reg_re one cycle after the header, then tx_load with 0x08; the dummy byte gives tx_load with 0x08, the next gives 0x00.
- Header 0x01, byte 0x12, then ss drops -> no reg_we; frame_err pulse; busy=0 the next cycle.
- Header 0x05 (NUM_REGS=4) followed by 0xAA, 0xBB -> frame_err one cycle after the header; no reg_we/reg_re; tx_byte=0x00.
- rst_n low during WDATA after one byte -> all outputs at reset values immediately; a fresh frame 0x02, 0x34, 0x56 gives reg_we with addr 2, data 0x3456.
- With SPI_CMD_AUTOINC_EN: header 0x03, then 4 data bytes 0x11, 0x22, 0x33, 0x44 -> reg_we at addr 3 with 0x1122, then at addr 0 with 0x3344 (wrap).

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared encodings for the SPI command sequencer: FSM states, header layout
// and the idle MISO byte.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        RREQ  = 3'd3,
        RDATA = 3'd4,
        DRAIN = 3'd5
    } state_t;

    localparam int         RW_BIT       = 7;
    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/spi_word_buf.sv
// Byte<->word shift buffer for the SPI command sequencer: parallel load,
// MSB-first byte shift in/out, and a byte counter with empty/last flags.
module spi_word_buf #(
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              shift_in,
    input  logic              shift_out,
    input  logic [DATA_W-1:0] din,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] shifted,
    output logic [7:0]        next_byte,
    output logic              empty,
    output logic              last
);
    localparam int               BPW      = DATA_W / 8;
    localparam int               CNT_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] word_shl;
    logic [CNT_W-1:0]  cnt;

    assign word_shl  = word << 8;
    assign shifted   = word_shl | DATA_W'(byte_in);
    assign next_byte = word_shl[DATA_W-1 -: 8];
    assign empty     = (cnt == '0);
    assign last      = (cnt == LAST_CNT);

    // The owner clears the counter on the last byte, so it never wraps here.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= din;
            cnt  <= '0;
        end else if (shift_in) begin
            word <= shifted;
            cnt  <= cnt + 1'b1;
        end else if (shift_out) begin
            word <= word_shl;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frame-level SPI command decoder driving the register bank strobes.
// Build option: SPI_CMD_AUTOINC_EN enables burst access with wrapping address.
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              ss_act,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              tx_load,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err,
    output logic              busy
);
`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int                BYTES_PER_WORD = bytes_per_word(DATA_W);
    localparam logic [7:0]        NUM_REGS_B     = 8'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR      = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic              ss_prev;
    logic              word_done_q, word_done_d;
    logic              tx_load_d, reg_we_d, reg_re_d, frame_err_d;
    logic [7:0]        tx_byte_d;
    logic [ADDR_W-1:0] reg_addr_d, addr_inc;
    logic [DATA_W-1:0] reg_wdata_d;
    logic              buf_clr, buf_load, buf_shift_in, buf_shift_out;
    logic [DATA_W-1:0] buf_shifted;
    logic [7:0]        buf_next_byte;
    logic              buf_empty, buf_last;
    logic              hdr_ok, in_word;

    spi_word_buf #(
        .DATA_W (DATA_W)
    ) u_word_buf (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .clr       (buf_clr),
        .load      (buf_load),
        .shift_in  (buf_shift_in),
        .shift_out (buf_shift_out),
        .din       (reg_rdata),
        .byte_in   (rx_byte),
        .shifted   (buf_shifted),
        .next_byte (buf_next_byte),
        .empty     (buf_empty),
        .last      (buf_last)
    );

    // Any set bit above ADDR_W makes the address >= NUM_REGS, so one compare covers both rules.
    assign hdr_ok   = ({1'b0, rx_byte[6:0]} < NUM_REGS_B);
    assign addr_inc = (reg_addr == LAST_ADDR) ? '0 : reg_addr + 1'b1;
    assign in_word  = (state_q == WDATA) || (state_q == RREQ) || (state_q == RDATA);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        word_done_d   = word_done_q;
        tx_load_d     = 1'b0;
        tx_byte_d     = tx_byte;
        reg_addr_d    = reg_addr;
        reg_wdata_d   = reg_wdata;
        reg_we_d      = 1'b0;
        reg_re_d      = 1'b0;
        frame_err_d   = 1'b0;
        buf_clr       = 1'b0;
        buf_load      = 1'b0;
        buf_shift_in  = 1'b0;
        buf_shift_out = 1'b0;

        // Burst writes step the address once the write strobe has been seen.
        if (AUTOINC && reg_we) begin
            reg_addr_d = addr_inc;
        end

        if (state_q != IDLE && !ss_act) begin
            state_d     = IDLE;
            tx_byte_d   = TX_IDLE_BYTE;
            buf_clr     = 1'b1;
            word_done_d = 1'b0;
            frame_err_d = in_word && !(word_done_q && buf_empty);
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_act && !ss_prev) begin
                        state_d     = HDR;
                        tx_byte_d   = TX_IDLE_BYTE;
                        buf_clr     = 1'b1;
                        word_done_d = 1'b0;
                    end
                end
                HDR: begin
                    if (rx_valid) begin
                        if (!hdr_ok) begin
                            frame_err_d = 1'b1;
                            state_d     = DRAIN;
                        end else begin
                            reg_addr_d = rx_byte[ADDR_W-1:0];
                            if (rx_byte[RW_BIT]) begin
                                state_d  = RREQ;
                                reg_re_d = 1'b1;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        if (buf_last) begin
                            reg_we_d    = 1'b1;
                            reg_wdata_d = buf_shifted;
                            buf_clr     = 1'b1;
                            word_done_d = 1'b1;
                            state_d     = AUTOINC ? WDATA : DRAIN;
                        end else begin
                            buf_shift_in = 1'b1;
                        end
                    end
                end
                RREQ: begin
                    buf_load  = 1'b1;
                    tx_load_d = 1'b1;
                    tx_byte_d = reg_rdata[DATA_W-1 -: 8];
                    state_d   = RDATA;
                end
                RDATA: begin
                    if (rx_valid) begin
                        tx_load_d = 1'b1;
                        if (buf_last) begin
                            tx_byte_d   = TX_IDLE_BYTE;
                            buf_clr     = 1'b1;
                            word_done_d = 1'b1;
                            if (AUTOINC) begin
                                state_d    = RREQ;
                                reg_re_d   = 1'b1;
                                reg_addr_d = addr_inc;
                            end else begin
                                state_d = DRAIN;
                            end
                        end else begin
                            buf_shift_out = 1'b1;
                            tx_byte_d     = buf_next_byte;
                        end
                    end
                end
                DRAIN: begin
                    tx_byte_d = TX_IDLE_BYTE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_prev     <= 1'b0;
            word_done_q <= 1'b0;
            tx_load     <= 1'b0;
            tx_byte     <= TX_IDLE_BYTE;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_prev     <= ss_act;
            word_done_q <= word_done_d;
            tx_load     <= tx_load_d;
            tx_byte     <= tx_byte_d;
            reg_addr    <= reg_addr_d;
            reg_wdata   <= reg_wdata_d;
            reg_we      <= reg_we_d;
            reg_re      <= reg_re_d;
            frame_err   <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed frames plus random frames checked
// against a byte-count model of the frame protocol.
`timescale 1ns/1ps
module tb_spi_cmd_sequencer;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 16;
    localparam int BPW      = DATA_W / 8;
`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ss_act = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              tx_load, reg_we, reg_re, frame_err, busy;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata, reg_rdata;

    int total = 0;
    int bad   = 0;

    logic              bank_load = 1'b0;
    logic [DATA_W-1:0] bank [NUM_REGS];
    logic [DATA_W-1:0] mdl  [NUM_REGS];

    logic [ADDR_W-1:0] we_a_q[$];
    logic [DATA_W-1:0] we_d_q[$];
    logic [ADDR_W-1:0] re_q[$];
    logic [7:0]        tx_q[$];
    int                err_seen = 0;

    always #5 sys_clk = ~sys_clk;

    spi_cmd_sequencer #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .ss_act    (ss_act),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_load   (tx_load),
        .tx_byte   (tx_byte),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Register bank stand-in: combinational read, write on reg_we.
    assign reg_rdata = (int'(reg_addr) < NUM_REGS) ? bank[reg_addr[1:0]] : '0;

    always @(posedge sys_clk) begin
        if (bank_load) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= mdl[i];
        end else if (reg_we && int'(reg_addr) < NUM_REGS) begin
            bank[reg_addr[1:0]] <= reg_wdata;
        end
    end

    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (reg_we) begin
                we_a_q.push_back(reg_addr);
                we_d_q.push_back(reg_wdata);
            end
            if (reg_re) re_q.push_back(reg_addr);
            if (tx_load) tx_q.push_back(tx_byte);
            if (frame_err) err_seen++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic clear_mon();
        we_a_q.delete();
        we_d_q.delete();
        re_q.delete();
        tx_q.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = DATA_W'($urandom);
        bank_load = 1'b1;
        gap(2);
        bank_load = 1'b0;
        if (tx_load !== 1'b0)    begin bad++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end total++;
        if (tx_byte !== 8'h00)   begin bad++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end total++;
        if (reg_addr !== '0)     begin bad++; $display("FAIL reset_reg_addr got=%0d exp=0", reg_addr); end total++;
        if (reg_wdata !== '0)    begin bad++; $display("FAIL reset_reg_wdata got=%h exp=0", reg_wdata); end total++;
        if ({reg_we, reg_re, frame_err, busy} !== 4'b0000)
            begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {reg_we, reg_re, frame_err, busy}); end total++;
        rst_n = 1'b1;
        gap(2);
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end total++;
    endtask

    task automatic test_write();
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h00);
        gap(2);
        send_byte(8'h08);
        if (reg_we !== 1'b0) begin bad++; $display("FAIL wr_early_we got=%b exp=0", reg_we); end total++;
        gap(2);
        send_byte(8'h08);
        if (reg_we !== 1'b1)       begin bad++; $display("FAIL wr_we got=%b exp=1", reg_we); end total++;
        if (reg_addr !== 3'd0)     begin bad++; $display("FAIL wr_addr got=%0d exp=0", reg_addr); end total++;
        if (reg_wdata !== 16'h0808) begin bad++; $display("FAIL wr_data got=%h exp=0808", reg_wdata); end total++;
        tick();
        if (reg_we !== 1'b0) begin bad++; $display("FAIL wr_we_pulse got=%b exp=0", reg_we); end total++;
        ss_act = 1'b0;
        tick();
        if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b exp=0", busy); end total++;
        gap(2);
        if (err_seen !== 0)       begin bad++; $display("FAIL wr_no_err got=%0d exp=0", err_seen); end total++;
        if (we_a_q.size() !== 1)  begin bad++; $display("FAIL wr_we_count got=%0d exp=1", we_a_q.size()); end total++;
        mdl[0] = 16'h0808;
    endtask

    task automatic test_read();
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h80);
        if (reg_re !== 1'b1)   begin bad++; $display("FAIL rd_re got=%b exp=1", reg_re); end total++;
        if (reg_addr !== 3'd0) begin bad++; $display("FAIL rd_addr got=%0d exp=0", reg_addr); end total++;
        tick();
        if ({reg_re, tx_load} !== 2'b01) begin bad++; $display("FAIL rd_msb_load got=%b exp=01", {reg_re, tx_load}); end total++;
        if (tx_byte !== 8'h08) begin bad++; $display("FAIL rd_msb got=%h exp=08", tx_byte); end total++;
        gap(2);
        send_byte(8'h00);
        if (tx_load !== 1'b1)  begin bad++; $display("FAIL rd_lsb_load got=%b exp=1", tx_load); end total++;
        if (tx_byte !== 8'h08) begin bad++; $display("FAIL rd_lsb got=%h exp=08", tx_byte); end total++;
        gap(2);
        send_byte(8'h00);
        if (tx_load !== 1'b1)  begin bad++; $display("FAIL rd_tail_load got=%b exp=1", tx_load); end total++;
        if (tx_byte !== 8'h00) begin bad++; $display("FAIL rd_tail got=%h exp=00", tx_byte); end total++;
        gap(2);
        ss_act = 1'b0;
        gap(2);
        if (err_seen !== 0)   begin bad++; $display("FAIL rd_no_err got=%0d exp=0", err_seen); end total++;
        if (re_q.size() < 1)  begin bad++; $display("FAIL rd_re_count got=%0d exp>=1", re_q.size()); end total++;
    endtask

    task automatic test_abort();
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h01);
        gap(2);
        send_byte(8'h12);
        gap(2);
        ss_act = 1'b0;
        tick();
        if (frame_err !== 1'b1) begin bad++; $display("FAIL abort_err got=%b exp=1", frame_err); end total++;
        if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end total++;
        tick();
        if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_err_pulse got=%b exp=0", frame_err); end total++;
        if (we_a_q.size() !== 0) begin bad++; $display("FAIL abort_no_we got=%0d exp=0", we_a_q.size()); end total++;
    endtask

    task automatic test_invalid_addr();
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h05);
        if (frame_err !== 1'b1) begin bad++; $display("FAIL inv_err got=%b exp=1", frame_err); end total++;
        tick();
        if (frame_err !== 1'b0) begin bad++; $display("FAIL inv_err_pulse got=%b exp=0", frame_err); end total++;
        gap(1);
        send_byte(8'hAA);
        gap(2);
        send_byte(8'hBB);
        gap(2);
        if (tx_byte !== 8'h00) begin bad++; $display("FAIL inv_tx_byte got=%h exp=00", tx_byte); end total++;
        ss_act = 1'b0;
        gap(2);
        if (we_a_q.size() + re_q.size() + tx_q.size() !== 0)
            begin bad++; $display("FAIL inv_no_strobe got=%0d exp=0", we_a_q.size() + re_q.size() + tx_q.size()); end total++;
        if (err_seen !== 1) begin bad++; $display("FAIL inv_err_count got=%0d exp=1", err_seen); end total++;
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h02);
        gap(2);
        send_byte(8'h34);
        gap(1);
        #2 rst_n = 1'b0;
        #1;
        if ({busy, reg_we, reg_re, frame_err, tx_load} !== 5'b0)
            begin bad++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {busy, reg_we, reg_re, frame_err, tx_load}); end total++;
        if (reg_addr !== '0)   begin bad++; $display("FAIL rst_mid_addr got=%0d exp=0", reg_addr); end total++;
        if (reg_wdata !== '0)  begin bad++; $display("FAIL rst_mid_wdata got=%h exp=0", reg_wdata); end total++;
        if (tx_byte !== 8'h00) begin bad++; $display("FAIL rst_mid_tx got=%h exp=00", tx_byte); end total++;
        ss_act = 1'b0;
        tick();
        rst_n = 1'b1;
        gap(2);
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h02);
        gap(2);
        send_byte(8'h34);
        gap(2);
        send_byte(8'h56);
        if (reg_we !== 1'b1)        begin bad++; $display("FAIL rst_fresh_we got=%b exp=1", reg_we); end total++;
        if (reg_addr !== 3'd2)      begin bad++; $display("FAIL rst_fresh_addr got=%0d exp=2", reg_addr); end total++;
        if (reg_wdata !== 16'h3456) begin bad++; $display("FAIL rst_fresh_data got=%h exp=3456", reg_wdata); end total++;
        gap(2);
        ss_act = 1'b0;
        gap(2);
        mdl[2] = 16'h3456;
    endtask

`ifdef SPI_CMD_AUTOINC_EN
    task automatic test_autoinc();
        clear_mon();
        ss_act = 1'b1;
        gap(2);
        send_byte(8'h03);
        gap(2);
        send_byte(8'h11);
        gap(2);
        send_byte(8'h22);
        if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 3'd3, 16'h1122})
            begin bad++; $display("FAIL autoinc_w0 got=%b/%0d/%h exp=1/3/1122", reg_we, reg_addr, reg_wdata); end total++;
        gap(2);
        send_byte(8'h33);
        gap(2);
        send_byte(8'h44);
        if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 3'd0, 16'h3344})
            begin bad++; $display("FAIL autoinc_w1 got=%b/%0d/%h exp=1/0/3344", reg_we, reg_addr, reg_wdata); end total++;
        gap(2);
        ss_act = 1'b0;
        gap(2);
        if (err_seen !== 0) begin bad++; $display("FAIL autoinc_no_err got=%0d exp=0", err_seen); end total++;
        mdl[3] = 16'h1122;
        mdl[0] = 16'h3344;
    endtask
`endif

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int                kind, n, pos, exp_err, nw;
            logic [7:0]        hdr;
            logic [7:0]        data[$];
            logic [ADDR_W-1:0] aa;
            logic [DATA_W-1:0] word, tmp;
            logic [ADDR_W-1:0] exp_wa[$];
            logic [DATA_W-1:0] exp_wd[$];
            logic [ADDR_W-1:0] exp_re[$];
            logic [7:0]        exp_tx[$];

            kind    = $urandom_range(0, 3);
            aa      = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            exp_err = 0;
            n       = 0;
            hdr     = 8'h00;
            case (kind)
                0: begin
                    hdr[6:0] = 7'($urandom_range(NUM_REGS, 127));
                    hdr[7]   = 1'($urandom_range(0, 1));
                    n        = $urandom_range(0, 3);
                    exp_err  = 1;
                end
                1: begin
                    hdr = 8'(aa);
                    n   = $urandom_range(1, AUTOINC ? 2 * BPW + 1 : BPW + 2);
                end
                2: begin
                    hdr = 8'h80 | 8'(aa);
                    n   = $urandom_range(0, AUTOINC ? 2 * BPW + 1 : BPW + 2);
                end
                default: n = 0;
            endcase
            for (int i = 0; i < n; i++) data.push_back(8'($urandom));

            if (kind == 1) begin
                nw      = AUTOINC ? n / BPW : ((n >= BPW) ? 1 : 0);
                exp_err = AUTOINC ? ((n % BPW) != 0) : (n < BPW);
                for (int w = 0; w < nw; w++) begin
                    word = '0;
                    for (int b = 0; b < BPW; b++) word = (word << 8) | DATA_W'(data[w * BPW + b]);
                    exp_wa.push_back(aa);
                    exp_wd.push_back(word);
                    mdl[aa[1:0]] = word;
                    aa = (int'(aa) == NUM_REGS - 1) ? '0 : aa + 1'b1;
                end
            end else if (kind == 2) begin
                exp_err = AUTOINC ? (n == 0 || (n % BPW) != 0) : (n < BPW);
                exp_re.push_back(aa);
                exp_tx.push_back(mdl[aa[1:0]][DATA_W-1 -: 8]);
                pos = 0;
                for (int k = 0; k < n; k++) begin
                    pos++;
                    if (pos < BPW) begin
                        tmp = mdl[aa[1:0]] << (8 * pos);
                        exp_tx.push_back(tmp[DATA_W-1 -: 8]);
                    end else begin
                        exp_tx.push_back(8'h00);
                        if (!AUTOINC) break;
                        aa = (int'(aa) == NUM_REGS - 1) ? '0 : aa + 1'b1;
                        exp_re.push_back(aa);
                        exp_tx.push_back(mdl[aa[1:0]][DATA_W-1 -: 8]);
                        pos = 0;
                    end
                end
            end

            clear_mon();
            ss_act = 1'b1;
            gap($urandom_range(2, 3));
            if (kind != 3) send_byte(hdr);
            for (int i = 0; i < n; i++) begin
                gap($urandom_range(2, 4));
                send_byte(data[i]);
            end
            gap($urandom_range(2, 4));
            ss_act = 1'b0;
            gap(3);

            if (we_a_q.size() !== exp_wa.size())
                begin bad++; $display("FAIL rnd%0d_we_count got=%0d exp=%0d", f, we_a_q.size(), exp_wa.size()); end total++;
            for (int i = 0; i < exp_wa.size() && i < we_a_q.size(); i++) begin
                if ({we_a_q[i], we_d_q[i]} !== {exp_wa[i], exp_wd[i]})
                    begin bad++; $display("FAIL rnd%0d_we%0d got=%0d/%h exp=%0d/%h", f, i, we_a_q[i], we_d_q[i], exp_wa[i], exp_wd[i]); end total++;
            end
            if (re_q.size() !== exp_re.size())
                begin bad++; $display("FAIL rnd%0d_re_count got=%0d exp=%0d", f, re_q.size(), exp_re.size()); end total++;
            for (int i = 0; i < exp_re.size() && i < re_q.size(); i++) begin
                if (re_q[i] !== exp_re[i])
                    begin bad++; $display("FAIL rnd%0d_re%0d got=%0d exp=%0d", f, i, re_q[i], exp_re[i]); end total++;
            end
            if (tx_q.size() !== exp_tx.size())
                begin bad++; $display("FAIL rnd%0d_tx_count got=%0d exp=%0d", f, tx_q.size(), exp_tx.size()); end total++;
            for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
                if (tx_q[i] !== exp_tx[i])
                    begin bad++; $display("FAIL rnd%0d_tx%0d got=%h exp=%h", f, i, tx_q[i], exp_tx[i]); end total++;
            end
            if (err_seen !== exp_err)
                begin bad++; $display("FAIL rnd%0d_err got=%0d exp=%0d", f, err_seen, exp_err); end total++;
            if ({busy, tx_byte} !== 9'h000)
                begin bad++; $display("FAIL rnd%0d_idle got=%b/%h exp=0/00", f, busy, tx_byte); end total++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_invalid_addr();
        test_reset_mid_frame();
`ifdef SPI_CMD_AUTOINC_EN
        test_autoinc();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
